// File: rtl/apb_req_pkg.sv
// apb_req_pkg: shared types for the request-to-APB initiator.
// FSM state encoding and the buffered response record.
package apb_req_pkg;

   localparam int unsigned APB_REQ_DW = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_req_state_e;

   typedef struct packed {
      logic [APB_REQ_DW-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_bus_if.sv
// APB_BUS: APB3 signal bundle shared by initiators and peripheral nodes.
// Master drives address/control/data, Slave returns data/ready/error.
interface APB_BUS #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic                  pwrite;
   logic                  psel;
   logic                  penable;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport Master (
      output paddr, pwdata, pwrite, psel, penable,
      input  prdata, pready, pslverr
   );

   modport Slave (
      input  paddr, pwdata, pwrite, psel, penable,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: saturating ACCESS-cycle counter with an expiry flag.
// Expiry fires on the last allowed cycle; TIMEOUT_CYCLES=0 never expires.
module apb_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired_o = 1'b0;
   end else begin : g_on
      assign expired_o = (cnt_q == CNT_LAST);
   end

endmodule

// File: rtl/apb_req_master.sv
// apb_req_master: single-outstanding valid/ready to APB3 initiator.
// SETUP/ACCESS sequencing, wait states, PSLVERR, timeout, one response.
module apb_req_master
   import apb_req_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = APB_REQ_DW,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      req_write_i,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      rsp_timeout_o,
   APB_BUS.Master                    apb_master
);

   apb_req_state_e state_q, state_d;
   apb_rsp_t       rsp_q, rsp_d;

   logic                      write_q;
   logic [APB_ADDR_WIDTH-1:0] addr_q;
   logic [APB_DATA_WIDTH-1:0] wdata_q;

   logic lat_en;
   logic cnt_clr;
   logic cnt_en;
   logic cnt_expired;

   apb_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (cnt_clr),
      .en_i      (cnt_en),
      .expired_o (cnt_expired)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rsp_d   = rsp_q;
      lat_en  = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               lat_en  = 1'b1;
               cnt_clr = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            cnt_en = 1'b1;
            // a ready peripheral wins over a simultaneous timeout
            if (apb_master.pready) begin
               rsp_d.rdata   = (write_q || apb_master.pslverr) ?
                               '0 : APB_REQ_DW'(apb_master.prdata);
               rsp_d.err     = apb_master.pslverr;
               rsp_d.timeout = 1'b0;
               state_d       = RESP;
            end else if (cnt_expired) begin
               rsp_d.rdata   = '0;
               rsp_d.err     = 1'b1;
               rsp_d.timeout = 1'b1;
               state_d       = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (lat_en) begin
         write_q <= req_write_i;
         addr_q  <= req_addr_i;
         wdata_q <= req_wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_q <= '0;
      end else begin
         rsp_q <= rsp_d;
      end
   end

   assign req_ready_o   = (state_q == IDLE);
   assign rsp_valid_o   = (state_q == RESP);
   assign rsp_rdata_o   = APB_DATA_WIDTH'(rsp_q.rdata);
   assign rsp_err_o     = rsp_q.err;
   assign rsp_timeout_o = rsp_q.timeout;

   // bus fields come straight from the request latch, so they simply
   // keep the previous transfer's values while idle
   assign apb_master.paddr   = addr_q;
   assign apb_master.pwdata  = wdata_q;
   assign apb_master.pwrite  = write_q;
   assign apb_master.psel    = (state_q == SETUP) || (state_q == ACCESS);
   assign apb_master.penable = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_req_master.sv
// tb_apb_req_master: vector table, corner sequences and random traffic
// against a transfer-level reference model of apb_req_master.
module tb_apb_req_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;

   APB_BUS #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

   apb_req_master #(
      .APB_ADDR_WIDTH(AW),
      .APB_DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_write_i   (req_write),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_err_o     (rsp_err),
      .rsp_timeout_o (rsp_timeout),
      .apb_master    (apb)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      bit          slverr;
      logic [31:0] e_rdata;
      bit          e_err;
      bit          e_to;
      int          e_lat;
      int          e_pen;
   } vec_t;

   vec_t        tbl [8];
   int          checks = 0;
   int          failures = 0;
   int          cur_waits = 0;
   int          acc_idx = 0;
   logic [31:0] cur_prdata = '0;
   bit          cur_slverr = 1'b0;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // peripheral: raises pready on ACCESS cycle number cur_waits
   task automatic slave_update();
      apb.prdata  = cur_prdata;
      apb.pslverr = cur_slverr;
      if (apb.psel && apb.penable) begin
         apb.pready = (acc_idx == cur_waits);
         acc_idx++;
      end else begin
         apb.pready = 1'b0;
         acc_idx    = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      slave_update();
   endtask

   // transfer-level outcome: penable cycles, latency and response
   function automatic vec_t model(input vec_t v);
      vec_t r;
      r = v;
      if (v.waits >= TO) begin
         r.e_pen   = TO;
         r.e_rdata = '0;
         r.e_err   = 1'b1;
         r.e_to    = 1'b1;
      end else begin
         r.e_pen   = v.waits + 1;
         r.e_rdata = (v.wr || v.slverr) ? 32'h0 : v.prdata;
         r.e_err   = v.slverr;
         r.e_to    = 1'b0;
      end
      r.e_lat = r.e_pen + 2;
      return r;
   endfunction

   task automatic do_xfer(input vec_t v, input int rsp_delay,
                          input bit hold);
      int k, g, first_sel, first_en, lat, sel_n, en_n;
      bit fld_ok, stall_ok;
      first_sel = -1;
      first_en  = -1;
      lat       = -1;
      sel_n     = 0;
      en_n      = 0;
      fld_ok    = 1'b1;
      cur_waits  = v.waits;
      cur_prdata = v.prdata;
      cur_slverr = v.slverr;
      req_valid = 1'b1;
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      g = 0;
      while (!req_ready && g < 20) begin
         tick();
         g++;
      end
      chk("req_ready_idle", req_ready, 1);
      tick();
      req_valid = hold;
      k = 1;
      while (k <= 64 && lat < 0) begin
         if (rsp_valid) begin
            lat = k;
         end else begin
            if (apb.psel) begin
               sel_n++;
               if (first_sel < 0) first_sel = k;
               if (apb.paddr !== v.addr || apb.pwrite !== v.wr ||
                   apb.pwdata !== v.wdata) fld_ok = 1'b0;
            end
            if (apb.penable) begin
               en_n++;
               if (first_en < 0) first_en = k;
            end
            tick();
            k++;
         end
      end
      chk("rsp_latency", lat, v.e_lat);
      chk("psel_first", first_sel, 1);
      chk("penable_first", first_en, 2);
      chk("penable_cycles", en_n, v.e_pen);
      chk("psel_cycles", sel_n, v.e_pen + 1);
      chk("apb_fields", fld_ok, 1);
      chk("rsp_rdata", rsp_rdata, v.e_rdata);
      chk("rsp_err", rsp_err, v.e_err);
      chk("rsp_timeout", rsp_timeout, v.e_to);
      for (int d = 0; d < rsp_delay; d++) begin
         rsp_ready = 1'b0;
         tick();
         stall_ok = rsp_valid && !req_ready && !apb.psel &&
                    rsp_rdata == v.e_rdata && rsp_err == v.e_err &&
                    rsp_timeout == v.e_to;
         chk("rsp_stall", stall_ok, 1);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   g;
      bit   ok;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      rsp_ready   = 1'b0;
      apb.pready  = 1'b0;
      apb.prdata  = '0;
      apb.pslverr = 1'b0;

      tbl[0] = '{wr:1, addr:32'h1A10_0000, wdata:32'hDEAD_BEEF, waits:0,
                 prdata:32'h1234_5678, slverr:0, e_rdata:32'h0, e_err:0,
                 e_to:0, e_lat:3, e_pen:1};
      tbl[1] = '{wr:0, addr:32'h1A10_1004, wdata:32'h0, waits:3,
                 prdata:32'h0000_00A5, slverr:0, e_rdata:32'hA5, e_err:0,
                 e_to:0, e_lat:6, e_pen:4};
      tbl[2] = '{wr:0, addr:32'h1A10_2000, wdata:32'h0, waits:1,
                 prdata:32'hFFFF_FFFF, slverr:1, e_rdata:32'h0, e_err:1,
                 e_to:0, e_lat:4, e_pen:2};
      tbl[3] = '{wr:0, addr:32'h1A10_3000, wdata:32'h0, waits:1000,
                 prdata:32'h55, slverr:0, e_rdata:32'h0, e_err:1,
                 e_to:1, e_lat:10, e_pen:8};
      tbl[4] = '{wr:0, addr:32'h1A10_1004, wdata:32'h0, waits:0,
                 prdata:32'hCAFE_F00D, slverr:0, e_rdata:32'hCAFE_F00D,
                 e_err:0, e_to:0, e_lat:3, e_pen:1};
      tbl[5] = '{wr:1, addr:32'h1A10_4008, wdata:32'h0BAD_CAFE, waits:2,
                 prdata:32'h9999_9999, slverr:1, e_rdata:32'h0, e_err:1,
                 e_to:0, e_lat:5, e_pen:3};
      tbl[6] = '{wr:0, addr:32'h1A10_5000, wdata:32'h0, waits:7,
                 prdata:32'h77, slverr:0, e_rdata:32'h77, e_err:0,
                 e_to:0, e_lat:10, e_pen:8};
      tbl[7] = '{wr:0, addr:32'h1A10_6000, wdata:32'h0, waits:8,
                 prdata:32'h88, slverr:0, e_rdata:32'h0, e_err:1,
                 e_to:1, e_lat:10, e_pen:8};

      #2 rst = 1'b1;
      #1;
      chk("reset_req_ready", req_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_rsp_err", rsp_err, 0);
      chk("reset_rsp_timeout", rsp_timeout, 0);
      chk("reset_psel", apb.psel, 0);
      chk("reset_penable", apb.penable, 0);
      chk("reset_paddr", apb.paddr, 0);
      chk("reset_pwdata", apb.pwdata, 0);
      chk("reset_pwrite", apb.pwrite, 0);
      #9 rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) do_xfer(tbl[i], i % 3, 1'b0);

      // response backpressure with the next request already waiting
      do_xfer(tbl[1], 5, 1'b1);
      chk("bp_idle_psel", apb.psel, 0);
      chk("bp_idle_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("bp_setup_psel", apb.psel, 1);
      chk("bp_setup_penable", apb.penable, 0);
      g = 0;
      while (!rsp_valid && g < 64) begin
         tick();
         g++;
      end
      chk("bp_second_rsp", rsp_valid, 1);
      chk("bp_second_rdata", rsp_rdata, 32'hA5);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      for (int i = 0; i < 40; i++) begin
         v.wr     = 1'($urandom_range(0, 1));
         v.addr   = $urandom;
         v.wdata  = $urandom;
         v.waits  = $urandom_range(0, 10);
         v.prdata = $urandom;
         v.slverr = ($urandom_range(0, 3) == 0);
         v = model(v);
         do_xfer(v, $urandom_range(0, 3), 1'b0);
      end

      // reset while a hung read is in ACCESS
      do_xfer(tbl[4], 0, 1'b0);
      cur_waits  = 1000;
      cur_prdata = 32'h1111_2222;
      cur_slverr = 1'b0;
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = 32'h1A10_2004;
      req_wdata  = 32'h3333_4444;
      tick();
      req_valid = 1'b0;
      g = 0;
      while (!apb.penable && g < 10) begin
         tick();
         g++;
      end
      chk("rst_reach_access", apb.penable, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_psel", apb.psel, 0);
      chk("rst_async_penable", apb.penable, 0);
      chk("rst_async_rsp_valid", rsp_valid, 0);
      tick();
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_paddr", apb.paddr, 0);
      chk("rst_pwdata", apb.pwdata, 0);
      #2 rst = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (apb.psel || !req_ready || rsp_valid) ok = 1'b0;
      end
      chk("rst_no_replay", ok, 1);

      // reset while a response is pending
      cur_waits = 0;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      g = 0;
      while (!rsp_valid && g < 10) begin
         tick();
         g++;
      end
      chk("rst_resp_reached", rsp_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_resp_drop", rsp_valid, 0);
      chk("rst_resp_ready", req_ready, 1);
      #3 rst = 1'b0;
      tick();

      do_xfer(tbl[0], 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
